tx_buffer_scheduler: RTL and testbench

- Owns the 4-byte transmit buffer (TXBUF) that the display block shows. Accepts byte writes from the board switches.
- On a send request, sequences the stored bytes in index order (0 to NUM_BYTES-1) into the UART transmitter using a valid/ready handshake, with a fixed idle gap between bytes.
- Sits between the user-input logic and the UART TX core, and exports TXBUF for the seven-segment display.

---
 rtl/tx_buffer_scheduler_pkg.sv | 17 +
 rtl/tx_buffer_scheduler_if.sv | 13 +
 rtl/tx_buffer_scheduler_rise_pulse.sv | 19 +
 rtl/tx_buffer_scheduler.sv | 164 ++++++++++++++++
 tb/tb_tx_buffer_scheduler.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/tx_buffer_scheduler_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int BYTE_W            = 8;
  localparam int DEFAULT_NUM_BYTES = 4;

  typedef logic [BYTE_W-1:0] byte_t;

  // Transmit scheduler states: waiting, offering a byte, idle gap, end-of-burst pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } txs_state_t;

endpackage

// File: rtl/tx_buffer_scheduler_if.sv
// Valid/ready byte channel between the transmit scheduler and the UART TX core.
interface tx_buffer_scheduler_if;
  import uart_pkg::*;

  logic  tx_valid;
  byte_t tx_data;
  logic  tx_ready;

  // The scheduler offers bytes; the UART core accepts them.
  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/tx_buffer_scheduler_rise_pulse.sv
// Registered rising-edge detector: one-cycle pulse on the first cycle a level is seen high.
module rise_pulse (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  // Remember last cycle's level so a held level produces only one pulse.
  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level_i;
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/tx_buffer_scheduler.sv
// Transmit buffer and burst scheduler. Holds NUM_BYTES bytes written from the
// switches, and on a rising edge of send streams them in index order into the
// UART TX core with a fixed idle gap after each accepted byte.
// Optional feature macro: TX_AUTO_REPEAT_EN adds repeat_mode, which restarts the
// burst from byte 0 instead of finishing while it is held high.
module tx_buffer_scheduler
  import uart_pkg::*;
#(
  parameter  int NUM_BYTES  = DEFAULT_NUM_BYTES,
  parameter  int GAP_CYCLES = 16,
  localparam int IDX_W      = $clog2(NUM_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send,
  input  logic                  load_en,
  input  logic [IDX_W-1:0]      load_addr,
  input  byte_t                 load_data,
`ifdef TX_AUTO_REPEAT_EN
  input  logic                  repeat_mode,
`endif
  tx_buffer_scheduler_if.master tx,
  output byte_t                 TXBUF [NUM_BYTES-1:0],
  output logic                  busy,
  output logic [IDX_W-1:0]      byte_idx,
  output logic                  done,
  output logic                  load_reject
);

  localparam int               CNT_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  if (GAP_CYCLES < 1) begin : g_gap_check
    $error("tx_buffer_scheduler: GAP_CYCLES must be at least 1");
  end
  if (NUM_BYTES < 2) begin : g_depth_check
    $error("tx_buffer_scheduler: NUM_BYTES must be at least 2");
  end

  txs_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic             reject_q, reject_d;
  logic             start;
  logic             addr_ok;
  logic             wr_ok;
  logic             xfer;

  rise_pulse u_send_edge (
    .clk     (clk),
    .rst     (rst),
    .level_i (send),
    .rise_o  (start)
  );

  // With a power-of-two depth every address selects a byte; otherwise the top
  // codes do not exist and such writes are refused.
  if ((1 << IDX_W) == NUM_BYTES) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    assign addr_ok = (int'(load_addr) < NUM_BYTES);
  end

  // Writes only land while idle and not in the cycle a burst starts, so a burst
  // always transmits the buffer as it stood when send rose.
  assign wr_ok    = load_en & (state_q == IDLE) & ~start & addr_ok;
  assign reject_d = load_en & ~wr_ok;
  assign xfer     = (state_q == ISSUE) & tx.tx_ready;

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_buf
    byte_t byte_q;

    // Capture a write aimed at this byte.
    always_ff @(posedge clk) begin
      if (rst)                                            byte_q <= '0;
      else if (wr_ok && (load_addr == IDX_W'(gi)))        byte_q <= load_data;
    end

    assign TXBUF[gi] = byte_q;
  end

  // State, byte index, gap counter and reject pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      gap_q    <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      reject_q <= reject_d;
    end
  end

  // Next-state sequencing and Moore outputs of the burst scheduler.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    tx.tx_valid = 1'b0;
    tx.tx_data  = '0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start) state_d = ISSUE;
      end

      ISSUE: begin
        busy        = 1'b1;
        tx.tx_valid = 1'b1;
        tx.tx_data  = TXBUF[idx_q];
        if (xfer) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end
      end

      GAP: begin
        busy = 1'b1;
        if (gap_q == '0) begin
          if (idx_q == LAST_IDX) begin
`ifdef TX_AUTO_REPEAT_EN
            if (repeat_mode) begin
              state_d = ISSUE;
              idx_d   = '0;
            end else begin
              state_d = DONE;
            end
`else
            state_d = DONE;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ISSUE;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
        idx_d   = '0;
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign byte_idx    = idx_q;
  assign load_reject = reject_q;

endmodule

// File: tb/tb_tx_buffer_scheduler.sv
// Self-checking bench for tx_buffer_scheduler: randomized data and ready stalls,
// checked against a timeline built from the burst rules (1-cycle start latency,
// GAP_CYCLES idle samples after each accepted byte, one done pulse).
module tb_tx_buffer_scheduler;
  import uart_pkg::*;

  localparam int NB  = 4;
  localparam int GAP = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic       load_en = 1'b0;
  logic [1:0] load_addr = '0;
  byte_t      load_data = '0;
`ifdef TX_AUTO_REPEAT_EN
  logic       repeat_mode = 1'b0;
`endif
  byte_t      txbuf [NB-1:0];
  logic       busy, done, load_reject;
  logic [1:0] byte_idx;

  tx_buffer_scheduler_if tx_if ();

  tx_buffer_scheduler #(
    .NUM_BYTES  (NB),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .send        (send),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
`ifdef TX_AUTO_REPEAT_EN
    .repeat_mode (repeat_mode),
`endif
    .tx          (tx_if),
    .TXBUF       (txbuf),
    .busy        (busy),
    .byte_idx    (byte_idx),
    .done        (done),
    .load_reject (load_reject)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  byte_t model [NB];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_buf(input string tag);
    for (int j = 0; j < NB; j++) chk(tag, 32'(txbuf[j]), 32'(model[j]));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(tx_if.tx_valid), 0);
    chk({tag, "_data"},  32'(tx_if.tx_data), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_idx"},   32'(byte_idx), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_rej"},   32'(load_reject), 0);
    chk_buf({tag, "_buf"});
  endtask

  task automatic do_write(input logic [1:0] a, input byte_t d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
    model[a] = d;
    $display("write addr %0d data %02h", a, d);
    chk("wr_rej", 32'(load_reject), 0);
    chk("wr_buf", 32'(txbuf[a]), 32'(d));
  endtask

  // One burst from a send rising edge; called at a negedge with the DUT idle and send low.
  task automatic run_burst(input int passes, input int stall_max, input int stall_byte,
                           input int stall_len, input bit wr_on_start, input bit wr_in_gap,
                           input int abort_byte);
    byte_t snap [NB];
    int    k;
    snap = model;
    send = 1'b1;
`ifdef TX_AUTO_REPEAT_EN
    repeat_mode = (passes > 1);
`endif
    if (wr_on_start) begin
      load_en = 1'b1; load_addr = 2'($urandom); load_data = 8'($urandom);
    end
    step();
    load_en = 1'b0;
    chk("start_rej", 32'(load_reject), 32'(wr_on_start));
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < NB; i++) begin
        k = (i == stall_byte) ? stall_len : $urandom_range(0, stall_max);
        for (int s = 0; s <= k; s++) begin
          chk("iss_valid", 32'(tx_if.tx_valid), 1);
          chk("iss_data",  32'(tx_if.tx_data), 32'(snap[i]));
          chk("iss_idx",   32'(byte_idx), 32'(i));
          chk("iss_busy",  32'(busy), 1);
          tx_if.tx_ready = (s == k);
          if (s < k) step();
        end
`ifdef TX_AUTO_REPEAT_EN
        if (i == NB - 1) repeat_mode = (p < passes - 1);
`endif
        step();
        $display("tx pass %0d byte %0d data %02h stall %0d", p, i, snap[i], k);
        tx_if.tx_ready = 1'($urandom);
        for (int g = 0; g < GAP; g++) begin
          chk("gap_valid", 32'(tx_if.tx_valid), 0);
          chk("gap_idx",   32'(byte_idx), 32'(i));
          chk("gap_busy",  32'(busy), 1);
          chk("gap_done",  32'(done), 0);
          chk("gap_rej",   32'(load_reject), 32'(wr_in_gap && p == 0 && i == 0 && g == 3));
          if (i == abort_byte && g == 3) begin
            rst = 1'b1; send = 1'b0; tx_if.tx_ready = 1'b0;
            step();
            for (int j = 0; j < NB; j++) model[j] = 8'h00;
            chk_idle("abort");
            rst = 1'b0;
            return;
          end
          if (wr_in_gap && p == 0 && i == 0 && g == 2) begin
            load_en = 1'b1; load_addr = 2'd1; load_data = 8'hFF;
          end else begin
            load_en = 1'b0;
          end
          step();
        end
      end
    end
    chk("done_pulse", 32'(done), 1);
    chk("done_busy",  32'(busy), 1);
    chk("done_valid", 32'(tx_if.tx_valid), 0);
    chk_buf("done_buf");
    tx_if.tx_ready = 1'b0;
    step();
    chk("end_done", 32'(done), 0);
    chk("end_busy", 32'(busy), 0);
    chk("end_idx",  32'(byte_idx), 0);
    $display("burst complete passes %0d", passes);
  endtask

  initial begin
    tx_if.tx_ready = 1'b0;
    for (int j = 0; j < NB; j++) model[j] = 8'h00;
    @(negedge clk);
    repeat (3) step();
    chk_idle("reset");
    rst = 1'b0;
    step();
    chk_idle("post_reset");

    // Directed pattern with ready always accepted immediately.
    do_write(2'd0, 8'hA1); do_write(2'd1, 8'hB2);
    do_write(2'd2, 8'hC3); do_write(2'd3, 8'hD4);
    run_burst(1, 0, -1, 0, 1'b0, 1'b0, -1);
    send = 1'b0; step();

    // Five-cycle stall on byte 2, then a write during the gap of byte 0.
    run_burst(1, 0, 2, 5, 1'b0, 1'b0, -1);
    send = 1'b0; step();
    run_burst(1, 0, -1, 0, 1'b0, 1'b1, -1);
    chk("b1_kept", 32'(txbuf[1]), 32'h0000_00B2);
    send = 1'b0; step();

    // Write in the same cycle as the start edge, then send held high long after the burst.
    run_burst(1, 2, -1, 0, 1'b1, 1'b0, -1);
    for (int c = 0; c < 130; c++) begin
      chk("hold_valid", 32'(tx_if.tx_valid), 0);
      chk("hold_busy",  32'(busy), 0);
      step();
    end
    send = 1'b0; step();
    run_burst(1, 0, -1, 0, 1'b0, 1'b0, -1);
    send = 1'b0; step();

    // Randomized buffer contents and ready stalls.
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 5; w++) do_write(2'($urandom), 8'($urandom));
      run_burst(1, 3, -1, 0, 1'($urandom), 1'($urandom), -1);
      send = 1'b0; step();
    end

    // Reset in the gap after byte 1, then a burst of the cleared buffer.
    run_burst(1, 0, -1, 0, 1'b0, 1'b0, 1);
    step();
    chk_idle("after_abort");
    run_burst(1, 1, -1, 0, 1'b0, 1'b0, -1);
    send = 1'b0; step();

`ifdef TX_AUTO_REPEAT_EN
    do_write(2'd0, 8'hA1); do_write(2'd1, 8'hB2);
    do_write(2'd2, 8'hC3); do_write(2'd3, 8'hD4);
    run_burst(3, 1, -1, 0, 1'b0, 1'b0, -1);
    send = 1'b0; step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
